// File: rtl/rsa_pkg.sv
// Shared constants and FSM state type for the RSA encrypt datapath.
package rsa_pkg;

  localparam int RSA_WIDTH   = 32;
  // Start-sample edge to done-rise, in clock cycles.
  localparam int RSA_ENC_LAT = 2*RSA_WIDTH*(RSA_WIDTH+1)+2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQR,
    MUL,
    DONE
  } rsa_state_e;

endpackage

// File: rtl/mod_mul_serial.sv
// Bit-serial modular multiplier: p = a*b mod n, MSB-first interleaved
// shift-add with two conditional subtractions per step. The go edge already
// performs the first step, so rdy pulses WIDTH cycles after go.
// Requires a, b < n; the partial remainder stays < n throughout.
import rsa_pkg::*;

module mod_mul_serial #(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             rdy,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_n;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic             r_rdy;

  logic [WIDTH-1:0] w_r_in;
  logic             w_bit;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_mod;
  logic [WIDTH+1:0] w_t0;
  logic [WIDTH+1:0] w_t1;
  logic [WIDTH-1:0] w_next;

  // One shift-add-reduce step; on go it starts from zero using the live operands.
  always_comb begin
    w_r_in = go ? '0 : r_acc;
    w_bit  = go ? b[WIDTH-1] : r_b[WIDTH-1];
    w_add  = go ? a : r_a;
    w_mod  = go ? n : r_n;
    w_t0   = {1'b0, w_r_in, 1'b0} + (w_bit ? {2'b00, w_add} : '0);
    w_t1   = (w_t0 >= {2'b00, w_mod}) ? w_t0 - {2'b00, w_mod} : w_t0;
    w_next = (w_t1 >= {2'b00, w_mod}) ? WIDTH'(w_t1 - {2'b00, w_mod})
                                      : WIDTH'(w_t1);
  end

  // Iteration control: down-counter of remaining steps, rdy on terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_n   <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
      r_rdy <= 1'b0;
    end else if (go) begin
      r_acc <= w_next;
      r_a   <= a;
      r_b   <= b << 1;
      r_n   <= n;
      r_cnt <= CW'(WIDTH-1);
      r_run <= 1'b1;
      r_rdy <= 1'b0;
    end else if (r_run) begin
      r_acc <= w_next;
      r_b   <= r_b << 1;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_run <= 1'b0;
        r_rdy <= 1'b1;
      end
    end else begin
      r_rdy <= 1'b0;
    end
  end

  assign rdy = r_rdy;
  assign p   = r_acc;

endmodule

// File: rtl/rsa_encrypt_core.sv
// RSA public-key operation: result = msg^e mod n, constant-time left-to-right
// square-and-multiply over all WIDTH exponent bits using one shared
// mod_mul_serial. Optional operand range check under RSA_ENC_RANGE_CHECK_EN.
import rsa_pkg::*;

module rsa_encrypt_core #(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int KW = $clog2(WIDTH);

  rsa_state_e       r_state;
  logic [WIDTH-1:0] r_msg;
  logic [WIDTH-1:0] r_e;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_acc;
  logic [KW-1:0]    r_k;
  logic             r_go;
  logic [WIDTH-1:0] r_ma;
  logic [WIDTH-1:0] r_mb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
`ifdef RSA_ENC_RANGE_CHECK_EN
  logic             r_err;
`endif

  logic             w_rdy;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_acc_next;

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (r_go),
    .a     (r_ma),
    .b     (r_mb),
    .n     (r_n),
    .rdy   (w_rdy),
    .p     (w_p)
  );

  // MUL always runs; the exponent bit only decides whether its product is kept.
  assign w_acc_next = r_e[r_k] ? w_p : r_acc;

  // Sequencer: operand latch, square/multiply alternation, result hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_msg    <= '0;
      r_e      <= '0;
      r_n      <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_go     <= 1'b0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
`ifdef RSA_ENC_RANGE_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_go <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_msg   <= msg;
            r_e     <= e;
            r_n     <= n;
            r_busy  <= 1'b1;
            r_state <= LOAD;
`ifdef RSA_ENC_RANGE_CHECK_EN
            r_err   <= 1'b0;
`endif
          end
        end
        LOAD: begin
          r_acc   <= WIDTH'(1);
          r_k     <= KW'(WIDTH-1);
          r_state <= SQR;
`ifdef RSA_ENC_RANGE_CHECK_EN
          if ((r_msg >= r_n) || (r_n < WIDTH'(2))) begin
            r_err <= 1'b1;
          end else begin
            r_go <= 1'b1;
            r_ma <= WIDTH'(1);
            r_mb <= WIDTH'(1);
          end
`else
          r_go    <= 1'b1;
          r_ma    <= WIDTH'(1);
          r_mb    <= WIDTH'(1);
`endif
        end
        SQR: begin
`ifdef RSA_ENC_RANGE_CHECK_EN
          if (r_err) begin
            r_state <= DONE;
          end else
`endif
          if (w_rdy) begin
            r_acc   <= w_p;
            r_ma    <= w_p;
            r_mb    <= r_msg;
            r_go    <= 1'b1;
            r_state <= MUL;
          end
        end
        MUL: begin
          if (w_rdy) begin
            r_acc <= w_acc_next;
            if (r_k == '0) begin
              r_state <= DONE;
            end else begin
              r_k     <= r_k - KW'(1);
              r_ma    <= w_acc_next;
              r_mb    <= w_acc_next;
              r_go    <= 1'b1;
              r_state <= SQR;
            end
          end
        end
        DONE: begin
          // First cycle publishes the result; second cycle (done high) returns
          // to IDLE, so a start coinciding with done is not accepted.
          if (!r_done) begin
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
`ifdef RSA_ENC_RANGE_CHECK_EN
            r_result <= r_err ? '0 : r_acc;
`else
            r_result <= r_acc;
`endif
          end else begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
`ifdef RSA_ENC_RANGE_CHECK_EN
  assign err    = r_err;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_encrypt_core.sv
// Self-checking bench for rsa_encrypt_core against a right-to-left modexp model.
module tb_rsa_encrypt_core;

  localparam int W       = 32;
  localparam int EXP_LAT = 2*W*(W+1)+2;
  localparam int LIMIT   = 3000;
  localparam logic [31:0] NTEST = 32'd4717;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  msg, e, n;
  logic          busy, done, err;
  logic [W-1:0]  result;

  int n_tests = 0;
  int n_fail  = 0;

  rsa_encrypt_core #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .msg    (msg),
    .e      (e),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #(900000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_modexp(input logic [31:0] m, input logic [31:0] ee,
                                               input logic [31:0] nn);
    longint unsigned base, acc, ex, md;
    md   = longint'(nn);
    base = longint'(m) % md;
    acc  = 1;
    ex   = longint'(ee);
    while (ex != 0) begin
      if (ex[0]) acc = (acc * base) % md;
      base = (base * base) % md;
      ex   = ex >> 1;
    end
    return 32'(acc % md);
  endfunction

  // Drives one operation and measures it; pulse_a/pulse_b inject extra start
  // pulses (with junk operands) at those cycle numbers after the start edge.
  task automatic run_op(input logic [31:0] m, input logic [31:0] ee, input logic [31:0] nn,
                        input int pulse_a, input int pulse_b,
                        output logic [31:0] res, output logic er,
                        output int lat, output int busy_low);
    @(posedge clk);
    @(negedge clk);
    msg = m; e = ee; n = nn; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; msg = $urandom; e = $urandom; n = $urandom;
    lat = -1; busy_low = 0; res = '0; er = 1'b0;
    for (int c = 1; c <= LIMIT; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c; res = result; er = err;
        break;
      end
      if (!busy) busy_low++;
      @(negedge clk);
      start = ((c+1) == pulse_a) || ((c+1) == pulse_b);
      msg = $urandom; e = $urandom; n = $urandom;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; msg = '0; e = '0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (result !== '0)  begin n_fail++; $display("FAIL reset_result got %0d want 0", result); end
    n_tests++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_known;
    logic [31:0] res; logic er; int lat, bl;
    run_op(32'd2, 32'd17, NTEST, 0, 0, res, er, lat, bl);
    n_tests++; if (res !== 32'd3713)  begin n_fail++; $display("FAIL known_result got %0d want 3713", res); end
    n_tests++; if (lat != EXP_LAT)    begin n_fail++; $display("FAIL known_latency got %0d want %0d", lat, EXP_LAT); end
    n_tests++; if (bl != 0)           begin n_fail++; $display("FAIL known_busy low_cycles got %0d want 0", bl); end
    n_tests++; if (er !== 1'b0)       begin n_fail++; $display("FAIL known_err got %b want 0", er); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0)     begin n_fail++; $display("FAIL done_pulse_width got %b want 0", done); end
    n_tests++; if (result !== 32'd3713) begin n_fail++; $display("FAIL result_hold got %0d want 3713", result); end
  endtask

  typedef struct { logic [31:0] m; logic [31:0] ee; logic [31:0] want; } bcase_t;

  task automatic test_boundaries;
    bcase_t tbl[5];
    logic [31:0] res; logic er; int lat, bl;
    tbl[0] = '{32'd3,    32'd3,  32'd27};
    tbl[1] = '{32'd1234, 32'd0,  32'd1};
    tbl[2] = '{32'd1234, 32'd1,  32'd1234};
    tbl[3] = '{32'd4716, 32'd2,  32'd1};
    tbl[4] = '{32'd0,    32'd17, 32'd0};
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].m, tbl[i].ee, NTEST, 0, 0, res, er, lat, bl);
      n_tests++; if (res !== tbl[i].want) begin n_fail++;
        $display("FAIL boundary_%0d result got %0d want %0d", i, res, tbl[i].want); end
      n_tests++; if (lat != EXP_LAT) begin n_fail++;
        $display("FAIL boundary_%0d latency got %0d want %0d", i, lat, EXP_LAT); end
    end
  endtask

  task automatic test_random;
    logic [31:0] res, m, ee, nn, want; logic er; int lat, bl;
    for (int i = 0; i < 6; i++) begin
      nn = (i < 3) ? NTEST : $urandom;
      if (nn < 2) nn = 32'd2;
      m  = 32'(longint'($urandom) % longint'(nn));
      ee = $urandom;
      want = model_modexp(m, ee, nn);
      run_op(m, ee, nn, 0, 0, res, er, lat, bl);
      n_tests++; if (res !== want) begin n_fail++;
        $display("FAIL random_%0d result got %0h want %0h (m=%0h e=%0h n=%0h)", i, res, want, m, ee, nn); end
      n_tests++; if (lat != EXP_LAT || bl != 0) begin n_fail++;
        $display("FAIL random_%0d timing got lat=%0d busy_low=%0d want lat=%0d busy_low=0", i, lat, bl, EXP_LAT); end
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] res; logic er; int lat, bl;
    @(posedge clk);
    @(negedge clk);
    msg = 32'd2; e = 32'd17; n = NTEST; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL midreset_done got %b want 0", done); end
    n_tests++; if (result !== '0)  begin n_fail++; $display("FAIL midreset_result got %0d want 0", result); end
    n_tests++; if (err !== 1'b0)   begin n_fail++; $display("FAIL midreset_err got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd3, 32'd3, NTEST, 0, 0, res, er, lat, bl);
    n_tests++; if (res !== 32'd27 || lat != EXP_LAT) begin n_fail++;
      $display("FAIL after_reset got result=%0d lat=%0d want 27 lat=%0d", res, lat, EXP_LAT); end
  endtask

  task automatic test_start_ignored;
    logic [31:0] res; logic er; int lat, bl;
    run_op(32'd2, 32'd17, NTEST, 10, 1000, res, er, lat, bl);
    n_tests++; if (res !== 32'd3713) begin n_fail++; $display("FAIL ignored_start result got %0d want 3713", res); end
    n_tests++; if (lat != EXP_LAT)   begin n_fail++; $display("FAIL ignored_start latency got %0d want %0d", lat, EXP_LAT); end
    // start asserted while done is high must not be accepted
    @(negedge clk);
    msg = 32'd5; e = 32'd5; n = NTEST; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_on_done busy got %b want 0", busy); end
    n_tests++; if (result !== 32'd3713) begin n_fail++; $display("FAIL start_on_done result got %0d want 3713", result); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res; logic er; int lat, bl;
    run_op(32'd7, 32'd65537, NTEST, 0, 0, res, er, lat, bl);
    run_op(32'd11, 32'd3, NTEST, 0, 0, res, er, lat, bl);
    n_tests++; if (res !== 32'd1331 || lat != EXP_LAT) begin n_fail++;
      $display("FAIL back_to_back got result=%0d lat=%0d want 1331 lat=%0d", res, lat, EXP_LAT); end
  endtask

`ifdef RSA_ENC_RANGE_CHECK_EN
  task automatic test_range_check;
    logic [31:0] res; logic er; int lat, bl;
    run_op(32'd4717, 32'd17, NTEST, 0, 0, res, er, lat, bl);
    n_tests++; if (er !== 1'b1 || res !== '0 || lat != 3) begin n_fail++;
      $display("FAIL range_msg got err=%b result=%0d lat=%0d want err=1 result=0 lat=3", er, res, lat); end
    run_op(32'd0, 32'd17, 32'd1, 0, 0, res, er, lat, bl);
    n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL range_n1 err got %b want 1", er); end
    run_op(32'd2, 32'd17, NTEST, 0, 0, res, er, lat, bl);
    n_tests++; if (er !== 1'b0 || res !== 32'd3713 || lat != EXP_LAT) begin n_fail++;
      $display("FAIL range_ok got err=%b result=%0d lat=%0d want err=0 result=3713", er, res, lat); end
  endtask
`endif

  initial begin
    test_reset();
    test_known();
    test_boundaries();
    test_random();
    test_async_reset();
    test_start_ignored();
    test_back_to_back();
`ifdef RSA_ENC_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
